// File: rtl/mw_cook_timer.sv
// Microwave cooking controller: keypad MM:SS entry, BCD countdown, power-level duty cycling,
// door-interlock pause/resume and timed done beep. Optional quick-start via QUICK_START_EN.
module mw_cook_timer #(
    parameter int TICKS_PER_SEC = 100,
    parameter int DUTY_WINDOW   = 10,
    parameter int BEEP_SECS     = 3
`ifdef QUICK_START_EN
    ,
    parameter int QUICK_SECS    = 30
`endif
) (
    input  logic       clk,
    input  logic       clearn,
    input  logic       enablen,
    input  logic [9:0] keypad,
    input  logic       startn,
    input  logic       stopn,
    input  logic       door_closed,
    input  logic [3:0] power_level,
    output logic       mag_on,
    output logic       done_beep,
    output logic [6:0] sec_ones_segs,
    output logic [6:0] sec_tens_segs,
    output logic [6:0] min_ones_segs,
    output logic [6:0] min_tens_segs
);

    localparam int PRE_W    = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int DUTY_W   = ($clog2(DUTY_WINDOW) > 4) ? $clog2(DUTY_WINDOW) : 4;
    localparam int BEEP_CYC = BEEP_SECS * TICKS_PER_SEC;
    localparam int BEEP_W   = (BEEP_CYC > 1) ? $clog2(BEEP_CYC) : 1;

`ifdef QUICK_START_EN
    localparam int QL_TOT = (QUICK_SECS > 5999) ? 5999 : QUICK_SECS;
    localparam int QL_MIN = QL_TOT / 60;
    localparam int QL_SEC = QL_TOT % 60;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_ENTRY,
        S_COOK,
        S_PAUSE,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [3:0][3:0]     dig_q, dig_d;      // [3]=min_tens .. [0]=sec_ones
    logic [PRE_W-1:0]    presc_q, presc_d;
    logic [DUTY_W-1:0]   duty_q, duty_d;
    logic [BEEP_W-1:0]   beep_cnt_q, beep_cnt_d;
    logic [3:0]          power_q, power_d;
    logic                startn_q, startn_d;
    logic                stopn_q, stopn_d;
    logic [9:0]          key_prev_q, key_prev_d;
    logic                mag_on_q, mag_on_d;
    logic                done_beep_q, done_beep_d;

    logic                start_press, stop_press, key_event, tick, time_zero, dec_zero;
    logic [3:0]          key_val;
    logic [3:0][3:0]     dec;
    logic [PRE_W-1:0]    presc_adv;
    logic [DUTY_W-1:0]   duty_adv;
`ifdef QUICK_START_EN
    int                  add_total, add_min, add_sec;
`endif

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b0111111;
            4'd1:    seg7 = 7'b0000110;
            4'd2:    seg7 = 7'b1011011;
            4'd3:    seg7 = 7'b1001111;
            4'd4:    seg7 = 7'b1100110;
            4'd5:    seg7 = 7'b1101101;
            4'd6:    seg7 = 7'b1111101;
            4'd7:    seg7 = 7'b0000111;
            4'd8:    seg7 = 7'b1111111;
            4'd9:    seg7 = 7'b1101111;
            default: seg7 = 7'b0000000;
        endcase
    endfunction

    // One-second decrement with BCD borrow; seconds above 59 count down unchanged.
    always_comb begin
        dec = dig_q;
        if (dig_q[0] != 4'd0) begin
            dec[0] = dig_q[0] - 4'd1;
        end else if (dig_q[1] != 4'd0) begin
            dec[0] = 4'd9;
            dec[1] = dig_q[1] - 4'd1;
        end else if (dig_q[2] != 4'd0 || dig_q[3] != 4'd0) begin
            dec[0] = 4'd9;
            dec[1] = 4'd5;
            if (dig_q[2] != 4'd0) begin
                dec[2] = dig_q[2] - 4'd1;
            end else begin
                dec[2] = 4'd9;
                dec[3] = dig_q[3] - 4'd1;
            end
        end
        dec_zero = (dec == '0);
    end

    always_comb begin
        key_val = 4'd0;
        for (int k = 0; k < 10; k++) begin
            if (keypad[k]) key_val = 4'(k);
        end
    end

    assign start_press = startn_q & ~startn;
    assign stop_press  = stopn_q & ~stopn;
    assign key_event   = ~enablen && $onehot(keypad) && (key_prev_q == '0);
    assign tick        = (presc_q == PRE_W'(TICKS_PER_SEC - 1));
    assign time_zero   = (dig_q == '0);
    assign presc_adv   = tick ? '0 : presc_q + 1'b1;
    assign duty_adv    = !tick ? duty_q :
                         (duty_q == DUTY_W'(DUTY_WINDOW - 1)) ? '0 : duty_q + 1'b1;

`ifdef QUICK_START_EN
    always_comb begin
        add_total = (int'(dig_q[3]) * 10 + int'(dig_q[2])) * 60
                  + int'(dig_q[1]) * 10 + int'(dig_q[0]) + QUICK_SECS - (tick ? 1 : 0);
        add_min   = add_total / 60;
        add_sec   = add_total % 60;
    end
`endif

    always_comb begin
        state_d     = state_q;
        dig_d       = dig_q;
        presc_d     = presc_q;
        duty_d      = duty_q;
        beep_cnt_d  = beep_cnt_q;
        power_d     = power_q;
        startn_d    = startn;
        stopn_d     = stopn;
        key_prev_d  = keypad;

        case (state_q)
            S_IDLE, S_ENTRY: begin
                if (start_press && !stop_press && door_closed && !time_zero) begin
                    power_d = (power_level == 4'd0 || power_level > 4'd10) ? 4'd10 : power_level;
                    presc_d = '0;
                    duty_d  = '0;
                    state_d = S_COOK;
`ifdef QUICK_START_EN
                end else if (start_press && !stop_press && door_closed && time_zero &&
                             state_q == S_IDLE) begin
                    dig_d   = {4'(QL_MIN / 10), 4'(QL_MIN % 10), 4'(QL_SEC / 10), 4'(QL_SEC % 10)};
                    power_d = 4'd10;
                    presc_d = '0;
                    duty_d  = '0;
                    state_d = S_COOK;
`endif
                end else if (key_event) begin
                    dig_d   = {dig_q[2], dig_q[1], dig_q[0], key_val};
                    state_d = S_ENTRY;
                end
            end
            S_COOK: begin
                // Door and stop both freeze the prescaler so resume picks up mid-second.
                if (!door_closed || stop_press) begin
                    state_d = S_PAUSE;
`ifdef QUICK_START_EN
                end else if (start_press) begin
                    presc_d = presc_adv;
                    duty_d  = duty_adv;
                    if (add_min > 99) begin
                        dig_d = {4'd9, 4'd9, 4'd5, 4'd9};
                    end else begin
                        dig_d = {4'(add_min / 10), 4'(add_min % 10),
                                 4'(add_sec / 10), 4'(add_sec % 10)};
                    end
`endif
                end else begin
                    presc_d = presc_adv;
                    duty_d  = duty_adv;
                    if (tick) begin
                        dig_d = dec;
                        if (dec_zero) begin
                            beep_cnt_d = '0;
                            state_d    = S_DONE;
                        end
                    end
                end
            end
            S_PAUSE: begin
                if (stop_press) begin
                    dig_d   = '0;
                    state_d = S_IDLE;
                end else if (start_press && door_closed) begin
                    state_d = S_COOK;
                end
            end
            S_DONE: begin
                if (stop_press || beep_cnt_q == BEEP_W'(BEEP_CYC - 1)) begin
                    dig_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    beep_cnt_d = beep_cnt_q + 1'b1;
                end
            end
            default: begin
                dig_d   = '0;
                state_d = S_IDLE;
            end
        endcase

        mag_on_d    = (state_d == S_COOK) && (duty_d < DUTY_W'(power_d));
        done_beep_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!clearn) begin
            state_q     <= S_IDLE;
            dig_q       <= '0;
            presc_q     <= '0;
            duty_q      <= '0;
            beep_cnt_q  <= '0;
            power_q     <= 4'd10;
            startn_q    <= 1'b1;
            stopn_q     <= 1'b1;
            key_prev_q  <= '0;
            mag_on_q    <= 1'b0;
            done_beep_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            dig_q       <= dig_d;
            presc_q     <= presc_d;
            duty_q      <= duty_d;
            beep_cnt_q  <= beep_cnt_d;
            power_q     <= power_d;
            startn_q    <= startn_d;
            stopn_q     <= stopn_d;
            key_prev_q  <= key_prev_d;
            mag_on_q    <= mag_on_d;
            done_beep_q <= done_beep_d;
        end
    end

    logic [6:0] segs_w [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_seg
            assign segs_w[gi] = seg7(dig_q[gi]);
        end
    endgenerate

    assign sec_ones_segs = segs_w[0];
    assign sec_tens_segs = segs_w[1];
    assign min_ones_segs = segs_w[2];
    assign min_tens_segs = segs_w[3];
    assign mag_on        = mag_on_q;
    assign done_beep     = done_beep_q;

endmodule

// File: doc/mw_cook_timer.md
Name: mw_cook_timer

Overview:
- Next-generation microwave cooking controller: keypad time entry, BCD MM:SS countdown, magnetron power-level duty cycling, door-interlock pause/resume, timed done beep.
- Drives four 7-segment digits plus mag_on and done_beep.
- Sits at top of the microwave datapath; replaces the fixed single-mode controller.

Parameters:
- TICKS_PER_SEC, 100, clk cycles per countdown second (sims use 4)
- DUTY_WINDOW, 10, seconds per power-level duty window
- BEEP_SECS, 3, seconds done_beep stays high in DONE
- QUICK_SECS, 30, seconds added per quick-start press (used only with QUICK_START_EN)

Ports:
- clk  input  1  system clock, rising edge
- clearn  input  1  synchronous active-low reset
- enablen  input  1  active-low keypad enable
- keypad  input  10  one-hot digit keys, bit k = digit k
- startn  input  1  active-low start, falling-edge detected
- stopn  input  1  active-low stop, falling-edge detected
- door_closed  input  1  1 = door shut
- power_level  input  4  1..10, sampled on start
- mag_on  output  1  magnetron enable
- done_beep  output  1  end-of-cook indicator
- sec_ones_segs, sec_tens_segs, min_ones_segs, min_tens_segs  output  7 each  segments {g,f,e,d,c,b,a}, active-high

Behaviour:
- Reset (clearn=0 at clk edge): state IDLE, digits 00:00, mag_on=0, done_beep=0, prescaler=0, edge registers = 1 (released), power register = 10. All segment outputs show "0" (7'b0111111).
- Inputs are sampled every clk. A press is a 1→0 transition of the registered startn/stopn.
- A key event requires enablen=0, keypad one-hot, and the previous sample all-zero. Multi-hot and held keys are ignored.
- States: IDLE, ENTRY, COOK, PAUSE, DONE.
- IDLE/ENTRY, key event: shift digits left (min_tens←min_ones←sec_tens←sec_ones←key); the old min_tens digit is discarded; go to ENTRY.
- Key events outside IDLE/ENTRY are ignored.
- start press in IDLE/ENTRY, time ≠ 00:00, door_closed=1:
  - latch power: 0 or >10 is stored as 10;
  - clear prescaler and duty-second counter;
  - go to COOK.
  Otherwise the press is ignored.
- COOK:
  - Prescaler counts 0..TICKS_PER_SEC-1. On wrap, decrement time by one second.
  - sec_ones 0 borrows from sec_tens. Sec 00 with minutes >0 loads sec 59 and decrements minutes (entered seconds up to 99 count down as-is).
  - When the decrement reaches 00:00, go to DONE the same edge.
- mag_on = (state==COOK) && (duty_sec < power), where duty_sec counts seconds 0..DUTY_WINDOW-1 and wraps. mag_on is a registered output.
- COOK, door_closed=0: go to PAUSE the next edge; mag_on=0 that edge; prescaler held.
- COOK, stop press: go to PAUSE.
- PAUSE, start press with door_closed=1: resume COOK; prescaler and duty counter continue from held values.
- PAUSE, stop press: clear time to 00:00; go to IDLE.
- DONE: done_beep=1 for BEEP_SECS×TICKS_PER_SEC cycles, then IDLE with 00:00. A stop press in DONE goes to IDLE immediately.
- Simultaneous start and stop press: stop wins.
- Door opening during COOK has priority over a start press in the same cycle.
- clearn=0 in any state aborts to reset values on that edge.

Optional Feature:
- Macro: QUICK_START_EN.
- Defined:
  - A start press in IDLE with 00:00 loads QUICK_SECS (BCD, normalised to MM:SS) and enters COOK at power 10.
  - A start press during COOK adds QUICK_SECS with carry into minutes; minutes saturate at 99:59.
- Undefined: a start press with 00:00 is ignored; a start press in COOK is ignored.

Test Plan (TICKS_PER_SEC=4, DUTY_WINDOW=10):
- Reset, then enablen=0, keys 1,2,3,0, start, door closed, power 10 → display 12:30; mag_on=1 next edge; display 12:29 after 4 cycles; 12:00→11:59 borrow correct.
- Entry 0:05, power 3 → mag_on high for seconds 0-2 and low for 3-4; DONE at 00:00; done_beep=1 for exactly 12 cycles; then IDLE.
- COOK at 0:20, door_closed=0 → mag_on=0 next edge, display frozen. Door closed plus start → countdown resumes from the held prescaler value.
- COOK, stop → PAUSE with time held; second stop → 00:00 IDLE. Start and stop pressed in the same cycle → stop behaviour.
- Multi-hot keypad 10'b0000000011, held key, enablen=1 → display unchanged. Start with 00:00 (macro off) → stays IDLE.
- QUICK_START_EN: start from IDLE 00:00 → 00:30 COOK. Start at 99:45 → 99:59 saturated.
